// File: rtl/apb_uart_fifo_bridge_if.sv
// APB slave bus bundle for the UART FIFO bridge.
interface apb_uart_fifo_bridge_if #(
  parameter int unsigned DATA_W = 32
);
  logic [3:0]        paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_uart_fifo_bridge.sv
// APB slave that queues words for byte-serial UART transmit and assembles
// received bytes into words for bus reads, with status and overrun reporting.
module apb_uart_fifo_bridge #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BYTE_W   = 8,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb_uart_fifo_bridge_if.slave apb,
  output logic                  tx_start,
  output logic [BYTE_W-1:0]     tx_data,
  input  logic                  tx_done,
  output logic                  rx_start,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_done
);

  localparam int unsigned NB     = DATA_W / BYTE_W;
  localparam int unsigned BCNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW  = TX_AW + 1;
  localparam int unsigned RX_AW  = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW  = RX_AW + 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NB - 1);

  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_SEND, T_WAIT} tx_state_t;

  tx_state_t         tx_state;
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0]  tx_count;
  logic [DATA_W-1:0] tx_shift;
  logic [BCNT_W-1:0] tx_bcnt;

  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0]  rx_count, rx_count_nxt;
  logic [DATA_W-1:0] rx_word, rx_asm;
  logic [BCNT_W-1:0] rx_bcnt;
  logic              rx_ovr;

  logic              access;
  logic [1:0]        reg_sel;
  logic              tx_full, tx_empty, rx_full, rx_empty, tx_busy;
  logic              wr_tx, rd_rx, wr_status;
  logic              tx_push, tx_pop, rx_push, rx_pop, rx_accept;
  logic [5:0]        status;
  logic [DATA_W-1:0] rdata;
  logic              rerr;
  logic              unused_addr;

  assign access      = apb.psel & apb.penable;
  assign reg_sel     = apb.paddr[3:2];
  assign unused_addr = ^apb.paddr[1:0];

  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign tx_busy  = (tx_state != T_IDLE);
  assign status   = {rx_ovr, tx_busy, rx_empty, rx_full, tx_empty, tx_full};

  assign wr_tx     = access &  apb.pwrite & (reg_sel == 2'd0);
  assign rd_rx     = access & ~apb.pwrite & (reg_sel == 2'd1);
  assign wr_status = access &  apb.pwrite & (reg_sel == 2'd2);

  // Flags are the registered values, so a full FIFO rejects a push even if it pops this cycle.
  assign tx_push   = wr_tx & ~tx_full;
  assign tx_pop    = (tx_state == T_LOAD);
  assign rx_pop    = rd_rx & ~rx_empty;
  assign rx_accept = rx_done & rx_start;
  assign rx_push   = rx_accept & (rx_bcnt == LAST_BYTE);

  // Register read mux and error decode.
  always_comb begin
    rdata = '0;
    rerr  = 1'b0;
    case (reg_sel)
      2'd0: rerr = ~apb.pwrite | tx_full;
      2'd1: begin
        if (apb.pwrite || rx_empty) rerr = 1'b1;
        else                        rdata = rx_mem[rx_rd_ptr];
      end
      2'd2: begin
        if (!apb.pwrite) rdata = DATA_W'(status);
      end
      default: rerr = 1'b1;
    endcase
  end

  assign apb.pready  = access;
  assign apb.pslverr = access & rerr;
  assign apb.prdata  = access ? rdata : '0;

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= apb.pwdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + TX_CW'(1);
        2'b01:   tx_count <= tx_count - TX_CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX serialiser: one word out as NB bytes, LSB first, each after the previous tx_done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= T_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      tx_shift <= '0;
      tx_bcnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          if (!tx_empty) tx_state <= T_LOAD;
        end
        T_LOAD: begin
          tx_shift <= tx_mem[tx_rd_ptr];
          tx_bcnt  <= '0;
          tx_state <= T_SEND;
        end
        T_SEND: begin
          tx_data  <= tx_shift[BYTE_W-1:0];
          tx_start <= 1'b1;
          tx_state <= T_WAIT;
        end
        T_WAIT: begin
          if (tx_done) begin
            tx_shift <= tx_shift >> BYTE_W;
            tx_bcnt  <= tx_bcnt + BCNT_W'(1);
            tx_state <= (tx_bcnt == LAST_BYTE) ? T_IDLE : T_SEND;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // Received byte dropped into its lane; the completed word is pushed in the same cycle.
  always_comb begin
    rx_asm = rx_word;
    rx_asm[32'(rx_bcnt) * BYTE_W +: BYTE_W] = rx_data;
  end

  always_comb begin
    rx_count_nxt = rx_count;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_nxt = rx_count + RX_CW'(1);
      2'b01:   rx_count_nxt = rx_count - RX_CW'(1);
      default: rx_count_nxt = rx_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_asm;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      rx_word   <= '0;
      rx_bcnt   <= '0;
      rx_ovr    <= 1'b0;
      rx_start  <= 1'b0;
    end else begin
      rx_count <= rx_count_nxt;
      rx_start <= (rx_count_nxt < RX_CW'(RX_DEPTH));
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      if (rx_accept) begin
        rx_word <= rx_asm;
        rx_bcnt <= rx_push ? '0 : rx_bcnt + BCNT_W'(1);
      end
      // A new overrun takes priority over a software clear in the same cycle.
      if (rx_done && !rx_start)                rx_ovr <= 1'b1;
      else if (wr_status && apb.pwdata[5])     rx_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo_bridge.sv
// Scoreboard bench for apb_uart_fifo_bridge: TX bytes and RX words are queued
// as stimulus is driven and checked as the DUT emits them.
module tb_apb_uart_fifo_bridge;
  localparam int unsigned DW  = 32;
  localparam int unsigned RXD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_start, rx_start;
  logic       tx_done = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] tx_data;
  logic [7:0] rx_data = 8'h00;

  always #5 clk = ~clk;

  apb_uart_fifo_bridge_if #(.DATA_W(DW)) apb ();

  apb_uart_fifo_bridge #(
    .DATA_W(DW), .BYTE_W(8), .TX_DEPTH(4), .RX_DEPTH(RXD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .apb(apb),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .rx_start(rx_start), .rx_data(rx_data), .rx_done(rx_done)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  txq[$];
  logic [31:0] rxq[$];
  logic [31:0] part = '0;
  int          rb = 0;
  bit          tx_auto = 1'b1;
  bit          outstanding = 1'b0;
  int          wait_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // TX engine model: checks each tx_start byte, answers with tx_done later.
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!rst_n) begin
      outstanding = 1'b0;
    end else if (tx_start) begin
      chk("tx_overlap", 32'(outstanding), 32'd0);
      if (txq.size() == 0) chk("tx_extra", 32'(tx_data), 32'hFFFF_FFFF);
      else                 chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
      outstanding = 1'b1;
      wait_cnt    = 2;
    end else if (outstanding && tx_auto) begin
      if (wait_cnt == 0) begin
        tx_done     = 1'b1;
        outstanding = 1'b0;
      end else begin
        wait_cnt--;
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = d;
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    chk("pready", 32'(apb.pready), 32'd1);
    rd  = apb.prdata;
    err = apb.pslverr;
    @(posedge clk);
    #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic apb_wr(input string tag, input logic [3:0] a, input logic [31:0] d, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b1, a, d, rd, err);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic apb_rd(input string tag, input logic [3:0] a, input logic [31:0] exp_d, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    apb_xfer(1'b0, a, 32'h0, rd, err);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic tx_write(input logic [31:0] d, input logic exp_err);
    apb_wr("txdata_wr", 4'h0, d, exp_err);
    if (!exp_err)
      for (int i = 0; i < 4; i++) txq.push_back(d[i*8 +: 8]);
  endtask

  task automatic rd_rx();
    if (rxq.size() == 0) apb_rd("rxdata_empty", 4'h4, 32'h0, 1'b1);
    else                 apb_rd("rxdata", 4'h4, rxq.pop_front(), 1'b0);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    chk("rx_start", 32'(rx_start), 32'(rxq.size() < RXD));
    rx_data = b;
    rx_done = 1'b1;
    if (rxq.size() < RXD) begin
      part[rb*8 +: 8] = b;
      rb++;
      if (rb == 4) begin
        rxq.push_back(part);
        rb = 0;
      end
    end
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (txq.size() != 0 || outstanding); i++) @(negedge clk);
    chk("tx_drain", 32'(txq.size()), 32'd0);
    chk("tx_done_all", 32'(outstanding), 32'd0);
  endtask

  initial begin
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 4'h0; apb.pwdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_pready", 32'(apb.pready), 32'd0);
    chk("rst_pslverr", 32'(apb.pslverr), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_rx_start", 32'(rx_start), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rx_start_up", 32'(rx_start), 32'd1);
    apb_rd("status_idle", 4'h8, 32'h0A, 1'b0);

    // Single word, LSB first
    tx_auto = 1'b1;
    tx_write(32'h4433_2211, 1'b0);
    wait_drain(200);
    repeat (5) @(negedge clk);
    apb_rd("status_tx_done", 4'h8, 32'h0A, 1'b0);

    // TX FIFO fill with the engine stalled
    tx_auto = 1'b0;
    for (int k = 0; k < 5; k++) tx_write(32'h1020_3040 + 32'(k) * 32'h0101_0101, 1'b0);
    tx_write(32'hDEAD_BEEF, 1'b1);
    apb_rd("status_tx_full", 4'h8, 32'h19, 1'b0);
    tx_auto = 1'b1;
    wait_drain(2000);
    repeat (5) @(negedge clk);
    apb_rd("status_tx_drained", 4'h8, 32'h0A, 1'b0);

    // Illegal accesses
    apb_rd("txdata_rd", 4'h0, 32'h0, 1'b1);
    apb_wr("rxdata_wr", 4'h4, 32'h1234_5678, 1'b1);
    apb_rd("reg3_rd", 4'hC, 32'h0, 1'b1);
    apb_wr("reg3_wr", 4'hC, 32'hFFFF_FFFF, 1'b1);
    apb_wr("status_wr", 4'h8, 32'h0000_001F, 1'b0);
    apb_rd("status_unchanged", 4'h8, 32'h0A, 1'b0);

    // RX word assembly
    rx_byte(8'hA1); rx_byte(8'hB2); rx_byte(8'hC3); rx_byte(8'hD4);
    rd_rx();
    rd_rx();

    // RX fill and overrun
    for (int i = 0; i < 16; i++) rx_byte(8'($urandom_range(0, 255)));
    rx_byte(8'h77);
    chk("rx_start_full", 32'(rx_start), 32'd0);
    apb_rd("status_ovr", 4'h8, 32'h26, 1'b0);
    apb_wr("status_clr", 4'h8, 32'h20, 1'b0);
    apb_rd("status_ovr_clr", 4'h8, 32'h06, 1'b0);
    for (int i = 0; i < 4; i++) rd_rx();
    rd_rx();
    apb_rd("status_rx_drained", 4'h8, 32'h0A, 1'b0);

    // Reset mid-word with TX waiting and a partial RX word
    tx_auto = 1'b0;
    tx_write(32'h8877_6655, 1'b0);
    for (int i = 0; i < 50 && !outstanding; i++) @(negedge clk);
    chk("tx_in_wait", 32'(outstanding), 32'd1);
    rx_byte(8'h01); rx_byte(8'h02);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_rx_start", 32'(rx_start), 32'd0);
    chk("mid_rst_pready", 32'(apb.pready), 32'd0);
    chk("mid_rst_pslverr", 32'(apb.pslverr), 32'd0);
    chk("mid_rst_prdata", apb.prdata, 32'h0);
    txq.delete();
    rxq.delete();
    part = '0;
    rb   = 0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    tx_auto = 1'b1;
    repeat (2) @(negedge clk);
    apb_rd("status_post_rst", 4'h8, 32'h0A, 1'b0);
    rx_byte(8'h5A); rx_byte(8'h6B); rx_byte(8'h7C); rx_byte(8'h8D);
    rd_rx();
    apb_rd("reg3_post_rst", 4'hC, 32'h0, 1'b1);
    repeat (10) @(negedge clk);
    chk("tx_quiet", 32'(txq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
